// File: rtl/pacman_dl_ctrl_if.sv
// Download bus between the HPS ioctl stream and the Pacman download
// sequencer. It carries the HPS byte stream with its back-pressure and the
// core-side download write port.
interface pacman_dl_ctrl_if;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;

  // HPS / test side: issues bytes and observes back-pressure and core writes
  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    input  ioctl_wait, dn_addr, dn_data, dn_wr
  );

  // Sequencer side
  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    output ioctl_wait, dn_addr, dn_data, dn_wr
  );
endinterface

// File: rtl/pacman_dl_ctrl.sv
// Pacman download sequencer.
// ROM bytes (index 0) go through a small FIFO that is drained one entry per
// ENA_6 slot into the core download port. Variant (index 1) and DIP bytes
// (index 254) are latched directly. The core is held in reset while ROM or
// variant data loads, and for HOLD_CYCLES clocks once the FIFO has drained.
module pacman_dl_ctrl #(
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 1024
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              ENA_6,
  pacman_dl_ctrl_if.slave   dl,
  output logic [7:0]        mod_sel,
  output logic [63:0]       dsw,
  output logic              core_reset,
  output logic              ovf
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_WAIT  = CNT_W'(FIFO_DEPTH - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_LOAD,
    ST_DRAIN,
    ST_HOLD
  } state_t;

  // FIFO storage and bookkeeping
  logic [23:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;

  // Output registers
  logic             wait_q;
  logic [15:0]      dn_addr_q;
  logic [7:0]       dn_data_q;
  logic             dn_wr_q;
  logic             ovf_q;
  logic [7:0]       mod_sel_q;
  logic [63:0]      dsw_q;

  // Sequencer state
  state_t           state_q;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic             core_reset_q;

  // Decoded strobes
  logic rom_wr, addr_in_rom, fifo_full, fifo_empty, push, pop, dl_start;

  assign rom_wr      = dl.ioctl_wr && (dl.ioctl_index == 8'd0);
  assign addr_in_rom = (dl.ioctl_addr[24:16] == 9'd0);
  assign fifo_full   = (count_q == CNT_FULL);
  assign fifo_empty  = (count_q == '0);
  assign pop         = ENA_6 && !fifo_empty;
  // A full FIFO still accepts a byte when the head leaves on the same edge.
  assign push        = rom_wr && addr_in_rom && (!fifo_full || pop);
  assign dl_start    = dl.ioctl_download &&
                       ((dl.ioctl_index == 8'd0) || (dl.ioctl_index == 8'd1));

  // Occupancy after this edge; feeds both the counter and ioctl_wait
  always_comb begin
    // NOTE: default first so every path assigns count_d and no latch is inferred.
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO data array
  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr_q] <= {dl.ioctl_addr[15:0], dl.ioctl_dout};
  end

  // FIFO pointers, back-pressure, drain output port and sticky overflow
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      wait_q    <= 1'b0;
      dn_addr_q <= '0;
      dn_data_q <= '0;
      dn_wr_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      count_q <= count_d;
      // Asserting one entry early leaves room for a strobe already in flight.
      wait_q  <= (count_d >= CNT_WAIT);
      dn_wr_q <= pop;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + PTR_W'(1);
        dn_addr_q <= fifo_mem[rd_ptr_q][23:8];
        dn_data_q <= fifo_mem[rd_ptr_q][7:0];
      end
      if (rom_wr && !push) ovf_q <= 1'b1;
    end
  end

  // Game-variant and DIP-bank latches
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      mod_sel_q <= 8'h00;
      dsw_q     <= '1;
    end else if (dl.ioctl_wr) begin
      if (dl.ioctl_index == 8'd1) mod_sel_q <= dl.ioctl_dout;
      if ((dl.ioctl_index == 8'd254) && (dl.ioctl_addr[24:3] == 22'd0))
        dsw_q[{dl.ioctl_addr[2:0], 3'b000} +: 8] <= dl.ioctl_dout;
    end
  end

  // Core reset sequencer: RUN -> LOAD -> DRAIN -> HOLD -> RUN
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q      <= ST_HOLD;
      hold_cnt_q   <= HOLD_LOAD;
      core_reset_q <= 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          // DIP-only downloads never disturb a running core.
          if (dl_start) begin
            state_q      <= ST_LOAD;
            core_reset_q <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (!dl.ioctl_download) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (dl_start) begin
            state_q <= ST_LOAD;
          end else if (fifo_empty && !dn_wr_q) begin
            state_q    <= ST_HOLD;
            hold_cnt_q <= HOLD_LOAD;
          end
        end
        ST_HOLD: begin
          if (dl_start) begin
            state_q <= ST_LOAD;
          end else if (hold_cnt_q == '0) begin
            state_q      <= ST_RUN;
            core_reset_q <= 1'b0;
          end else begin
            hold_cnt_q <= hold_cnt_q - HOLD_W'(1);
          end
        end
        default: begin
          state_q      <= ST_HOLD;
          hold_cnt_q   <= HOLD_LOAD;
          core_reset_q <= 1'b1;
        end
      endcase
    end
  end

  assign dl.ioctl_wait = wait_q;
  assign dl.dn_addr    = dn_addr_q;
  assign dl.dn_data    = dn_data_q;
  assign dl.dn_wr      = dn_wr_q;
  assign mod_sel       = mod_sel_q;
  assign dsw           = dsw_q;
  assign core_reset    = core_reset_q;
  assign ovf           = ovf_q;

endmodule
